// File: rtl/writeback_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : writeback_stage_if
//  Brief    : Memory-stage to write-back-stage bundle, covering the stage
//             inputs, stall/flush control and register file write port.
//  Revision : 1.0  initial release
// ============================================================================
interface writeback_stage_if #(
  parameter int CNT_W = 32
) ();
  // Instruction leaving the memory stage
  logic             mem_valid;
  logic             mem_regwrite;
  logic [4:0]       mem_wsel;
  logic [1:0]       mem_wbsrc;
  logic [31:0]      mem_aluout;
  logic [31:0]      mem_dload;
  logic [31:0]      mem_npc;
  logic [15:0]      mem_imm16;
  logic             mem_halt;
  // Pipeline control
  logic             wb_stall;
  logic             wb_flush;
  // Register file write port and status
  logic             WEN;
  logic [4:0]       wsel;
  logic [31:0]      wdat;
  logic             halt;
  logic [CNT_W-1:0] retired;

  // Upstream pipeline/controller side
  modport master (
    output mem_valid, mem_regwrite, mem_wsel, mem_wbsrc, mem_aluout,
           mem_dload, mem_npc, mem_imm16, mem_halt, wb_stall, wb_flush,
    input  WEN, wsel, wdat, halt, retired
  );

  // Write-back stage side
  modport slave (
    input  mem_valid, mem_regwrite, mem_wsel, mem_wbsrc, mem_aluout,
           mem_dload, mem_npc, mem_imm16, mem_halt, wb_stall, wb_flush,
    output WEN, wsel, wdat, halt, retired
  );
endinterface
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
//  Module   : writeback_stage
//  Brief    : MEM/WB pipeline register and write-back data selector. Drives
//             the register file write port, latches the sticky halt flag and
//             counts retired instructions.
//  Revision : 1.0  initial release
// ============================================================================
module writeback_stage #(
  parameter int CNT_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  writeback_stage_if.slave  bus
);

  localparam logic [1:0] c_SRC_ALU  = 2'b00;
  localparam logic [1:0] c_SRC_LOAD = 2'b01;
  localparam logic [1:0] c_SRC_LINK = 2'b10;
  localparam logic [1:0] c_SRC_LUI  = 2'b11;

  // Stage register
  logic             r_valid;
  logic             r_regwrite;
  logic [4:0]       r_wsel;
  logic [1:0]       r_wbsrc;
  logic [31:0]      r_aluout;
  logic [31:0]      r_dload;
  logic [31:0]      r_npc;
  logic [15:0]      r_imm16;
  // Status
  logic             r_halted;
  logic [CNT_W-1:0] r_retired;

  // A capture happens only when the stage is neither halted, flushed nor stalled
  logic w_capture;
  logic [31:0] w_wdat;

  assign w_capture = ~r_halted & ~bus.wb_flush & ~bus.wb_stall;

  // Stage register: halt or flush insert a bubble, stall holds, otherwise load
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_wsel     <= 5'd0;
      r_wbsrc    <= 2'd0;
      r_aluout   <= 32'd0;
      r_dload    <= 32'd0;
      r_npc      <= 32'd0;
      r_imm16    <= 16'd0;
    end else if (r_halted || bus.wb_flush) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_wsel     <= 5'd0;
      r_wbsrc    <= 2'd0;
      r_aluout   <= 32'd0;
      r_dload    <= 32'd0;
      r_npc      <= 32'd0;
      r_imm16    <= 16'd0;
    end else if (!bus.wb_stall) begin
      r_valid    <= bus.mem_valid;
      r_regwrite <= bus.mem_regwrite;
      r_wsel     <= bus.mem_wsel;
      r_wbsrc    <= bus.mem_wbsrc;
      r_aluout   <= bus.mem_aluout;
      r_dload    <= bus.mem_dload;
      r_npc      <= bus.mem_npc;
      r_imm16    <= bus.mem_imm16;
    end
  end

  // Sticky halt: set when a real HALT is captured, cleared only by reset
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_halted <= 1'b0;
    end else if (w_capture && bus.mem_valid && bus.mem_halt) begin
      r_halted <= 1'b1;
    end
  end

  // Retired counter: one per captured real instruction, HALT included, wraps
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_retired <= '0;
    end else if (w_capture && bus.mem_valid) begin
      r_retired <= r_retired + 1'b1;
    end
  end

  // Write-back data select from the stage register
  always_comb begin
    w_wdat = r_aluout;
    case (r_wbsrc)
      c_SRC_ALU:  w_wdat = r_aluout;
      c_SRC_LOAD: w_wdat = r_dload;
      c_SRC_LINK: w_wdat = r_npc;
      c_SRC_LUI:  w_wdat = {r_imm16, 16'h0000};
      default:    w_wdat = r_aluout;
    endcase
  end

  // Register 0 is hardwired, so a write to it is never issued
  assign bus.WEN     = r_valid & r_regwrite & (r_wsel != 5'd0);
  assign bus.wsel    = r_wsel;
  assign bus.wdat    = w_wdat;
  assign bus.halt    = r_halted;
  assign bus.retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_writeback_stage
//  Brief    : Self-checking bench for writeback_stage (4-bit retired counter
//             so the wrap is reachable) against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_writeback_stage;

  localparam int CNT_W = 4;

  logic CLK;
  logic nRST;

  writeback_stage_if #(.CNT_W(CNT_W)) bus ();

  writeback_stage #(.CNT_W(CNT_W)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Behavioural model of what the write port should show
  bit          e_valid;
  bit          e_wen;
  logic [4:0]  e_wsel;
  logic [31:0] e_wdat;
  bit          e_halted;
  int          e_retired;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    e_valid = 0; e_wen = 0; e_wsel = 5'd0; e_wdat = 32'd0;
    e_halted = 0; e_retired = 0;
  endtask

  task automatic drive(input bit v, input bit rw, input logic [4:0] ws,
                       input logic [1:0] src, input logic [31:0] alu,
                       input logic [31:0] dl, input logic [31:0] npc,
                       input logic [15:0] imm, input bit hlt,
                       input bit st, input bit fl);
    bus.mem_valid    = v;
    bus.mem_regwrite = rw;
    bus.mem_wsel     = ws;
    bus.mem_wbsrc    = src;
    bus.mem_aluout   = alu;
    bus.mem_dload    = dl;
    bus.mem_npc      = npc;
    bus.mem_imm16    = imm;
    bus.mem_halt     = hlt;
    bus.wb_stall     = st;
    bus.wb_flush     = fl;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".WEN"}, {31'd0, bus.WEN}, {31'd0, e_wen});
    chk({tag, ".halt"}, {31'd0, bus.halt}, {31'd0, e_halted});
    chk({tag, ".retired"}, {28'd0, bus.retired}, e_retired[31:0]);
    if (e_valid) begin
      chk({tag, ".wsel"}, {27'd0, bus.wsel}, {27'd0, e_wsel});
      chk({tag, ".wdat"}, bus.wdat, e_wdat);
    end
  endtask

  // One clock: advance the model by the stage rules, then check after the edge
  task automatic step(input string tag);
    @(posedge CLK);
    if (e_halted || bus.wb_flush) begin
      e_valid = 0;
      e_wen   = 0;
    end else if (!bus.wb_stall) begin
      e_valid = bus.mem_valid;
      e_wen   = bus.mem_valid && bus.mem_regwrite && (bus.mem_wsel != 0);
      e_wsel  = bus.mem_wsel;
      case (bus.mem_wbsrc)
        2'd0: e_wdat = bus.mem_aluout;
        2'd1: e_wdat = bus.mem_dload;
        2'd2: e_wdat = bus.mem_npc;
        default: e_wdat = 32'(bus.mem_imm16) * 32'd65536;
      endcase
      if (bus.mem_valid) begin
        e_retired = (e_retired + 1) % (1 << CNT_W);
        if (bus.mem_halt) e_halted = 1;
      end
    end
    #1;
    check_outputs(tag);
  endtask

  initial begin
    // Reset
    nRST = 1'b0;
    drive(0, 0, 5'd0, 2'd0, 32'd0, 32'd0, 32'd0, 16'd0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("reset.WEN", {31'd0, bus.WEN}, 32'd0);
    chk("reset.wsel", {27'd0, bus.wsel}, 32'd0);
    chk("reset.wdat", bus.wdat, 32'd0);
    chk("reset.halt", {31'd0, bus.halt}, 32'd0);
    chk("reset.retired", {28'd0, bus.retired}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // Single ALU write
    drive(1, 1, 5'd5, 2'd0, 32'h1234_5678, 32'd0, 32'd0, 16'd0, 0, 0, 0);
    step("single");
    chk("single.wdat_const", bus.wdat, 32'h1234_5678);

    // Four sources back to back
    for (int s = 0; s < 4; s++) begin
      drive(1, 1, 5'd7, 2'(s), 32'hA, 32'hB, 32'h104, 16'hBEEF, 0, 0, 0);
      step("src");
    end
    chk("src.lui_const", bus.wdat, 32'hBEEF_0000);

    // Write to register 0 suppressed but still retired
    drive(1, 1, 5'd0, 2'd0, 32'h55, 32'd0, 32'd0, 16'd0, 0, 0, 0);
    step("r0");

    // Capture A, then stall three cycles with different inputs
    drive(1, 1, 5'd9, 2'd0, 32'hAAAA_0001, 32'd0, 32'd0, 16'd0, 0, 0, 0);
    step("stallA");
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 5'(10 + i), 2'd1, 32'd0, $urandom, 32'd0, 16'd0, 0, 1, 0);
      step("stall");
    end
    chk("stall.held", bus.wdat, 32'hAAAA_0001);
    // Stall and flush together: flush wins
    drive(1, 1, 5'd3, 2'd0, 32'h77, 32'd0, 32'd0, 16'd0, 0, 1, 1);
    step("flush");

    // Randomised traffic without HALT
    for (int i = 0; i < 60; i++) begin
      drive(($urandom % 4) != 0, 1'($urandom), 5'($urandom), 2'($urandom),
            $urandom, $urandom, $urandom, 16'($urandom), 0,
            ($urandom % 5) == 0, ($urandom % 7) == 0);
      step("rand");
    end

    // Drive the counter to all-ones, then one more capture wraps to zero
    for (int i = 0; i < 20 && e_retired != (1 << CNT_W) - 1; i++) begin
      drive(1, 1, 5'd1, 2'd0, 32'(i), 32'd0, 32'd0, 16'd0, 0, 0, 0);
      step("fill");
    end
    drive(1, 1, 5'd2, 2'd0, 32'hCAFE, 32'd0, 32'd0, 16'd0, 0, 0, 0);
    step("wrap");
    chk("wrap.zero", {28'd0, bus.retired}, 32'd0);

    // Asynchronous reset in the middle of a stall
    drive(1, 1, 5'd4, 2'd0, 32'h4444, 32'd0, 32'd0, 16'd0, 0, 0, 0);
    step("prestall");
    drive(1, 1, 5'd6, 2'd0, 32'h6666, 32'd0, 32'd0, 16'd0, 0, 1, 0);
    step("midstall");
    #2;
    nRST = 1'b0;
    model_reset();
    #1;
    chk("areset.WEN", {31'd0, bus.WEN}, 32'd0);
    chk("areset.wsel", {27'd0, bus.wsel}, 32'd0);
    chk("areset.wdat", bus.wdat, 32'd0);
    chk("areset.retired", {28'd0, bus.retired}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    drive(1, 1, 5'd8, 2'd2, 32'd0, 32'd0, 32'h200, 16'd0, 0, 0, 0);
    step("postreset");

    // HALT then further writers: halt sticks, no writes, count frozen
    drive(1, 0, 5'd0, 2'd0, 32'd0, 32'd0, 32'd0, 16'd0, 1, 0, 0);
    step("halt");
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 5'(1 + i), 2'd0, $urandom, 32'd0, 32'd0, 16'd0, 0, 0, 0);
      step("halted");
    end
    chk("halted.count", {28'd0, bus.retired}, 32'd2);

    // Reset clears the sticky halt
    @(negedge CLK);
    nRST = 1'b0;
    model_reset();
    #1;
    chk("haltreset.halt", {31'd0, bus.halt}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    drive(1, 1, 5'd11, 2'd3, 32'd0, 32'd0, 32'd0, 16'h1234, 0, 0, 0);
    step("after_halt");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/writeback_stage.md
# writeback_stage

MEM/WB pipeline register and write-back selector for the pipelined datapath. It captures the instruction leaving the memory stage, selects the value to be written (ALU result, load data, link address or LUI immediate) and drives the register file write port (WEN, wsel, wdat). It also latches the halt condition for the core and counts retired instructions.

## Interface
- CNT_W, 32, width of the retired-instruction counter
- CLK  in  1  clock, rising-edge
- nRST  in  1  reset, asynchronous, active-low
- mem_valid  in  1  memory stage presents a real instruction (0 = bubble)
- mem_regwrite  in  1  instruction writes a register
- mem_wsel  in  5  destination register number
- mem_wbsrc  in  2  write-back source: 00 ALU, 01 load data, 10 link (npc), 11 LUI
- mem_aluout  in  32  ALU result
- mem_dload  in  32  load data returned by memory
- mem_npc  in  32  PC+4 of the instruction
- mem_imm16  in  16  immediate field
- mem_halt  in  1  instruction is HALT
- wb_stall  in  1  hold stage contents this cycle
- wb_flush  in  1  replace stage contents with a bubble this cycle
- WEN  out  1  register file write enable
- wsel  out  5  register file write address
- wdat  out  32  register file write data
- halt  out  1  core halted (sticky)
- retired  out  CNT_W  retired-instruction count

## Operation
- State: valid, regwrite, wsel, wbsrc, aluout, dload, npc, imm16 (stage register); halted (sticky flag); retired counter.
- Each rising edge, priority order:
  - halted = 1: stage register loads a bubble (valid = 0); nothing else changes.
  - wb_flush = 1: stage register loads a bubble; flush overrides wb_stall.
  - wb_stall = 1: stage register holds.
  - otherwise: stage register loads all mem_* fields.
- Capture of an instruction with mem_valid = 1 and mem_halt = 1 sets halted on the same edge; halted clears only on reset.
- retired increments by 1 on every edge where a mem_valid = 1 instruction is captured (not flushed, not stalled, not halted). HALT itself is counted. Wraps modulo 2^CNT_W.
- WEN = valid & regwrite & (wsel != 0); writes to register 0 are never issued.
- wdat selection (combinational from stage register):
  - 00: aluout; 01: dload; 10: npc; 11: {imm16, 16'h0000}.
- wsel driven directly from stage register regardless of WEN.
- While stalled with a valid writing instruction held, WEN stays asserted each cycle; repeated writes of the same value are acceptable.
- Bubble (valid = 0): WEN = 0; wsel and wdat reflect the bubble's fields (don't-care to the register file).

## Timing
- Reset (nRST low, asynchronous): all stage fields 0, halted 0, retired 0; hence WEN 0, wsel 0, wdat 0, halt 0, retired 0.
- Latency: mem_* sampled at edge N appear on WEN/wsel/wdat after edge N; register file commits at edge N+1.
- halt asserts in the cycle after the HALT instruction is captured, together with that instruction's own write-back outputs.
- retired reflects the new count immediately after the capturing edge.
- nRST asserted mid-stall or mid-halt: everything returns to reset values at once; next capture after release behaves normally.
- wb_stall and wb_flush are sampled only at the rising edge; no combinational path from them to outputs.

## Test plan
- Reset, then mem_valid=1, regwrite=1, wsel=5, wbsrc=00, aluout=0x1234_5678 -> next cycle WEN=1, wsel=5, wdat=0x1234_5678, retired=1.
- Four back-to-back instructions, wbsrc 00/01/10/11 with aluout=0xA, dload=0xB, npc=0x104, imm16=0xBEEF -> wdat sequence 0xA, 0xB, 0x104, 0xBEEF0000; retired=4.
- Write to wsel=0 with regwrite=1 -> WEN=0, retired still increments.
- Capture instruction A, then wb_stall=1 for 3 cycles with different mem_* -> A held on outputs for 4 cycles, retired unchanged during stall; wb_stall=1 and wb_flush=1 together -> bubble, WEN=0.
- HALT captured (mem_halt=1, regwrite=0) followed by valid writing instructions -> halt=1 from next cycle and stays 1, WEN=0 thereafter, retired stops at count including HALT.
- Set retired to 2^CNT_W-1 via instructions (or CNT_W=4 build, 15 captures) then one more capture -> retired wraps to 0; assert nRST mid-stall -> all outputs 0 asynchronously.
